// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU, one quotient bit per clock.
// result_o packs {remainder, quotient}; handshake mirrors the multiplier.
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               signed_div_i,
   input  logic [WIDTH-1:0]   opdata1_i,
   input  logic [WIDTH-1:0]   opdata2_i,
   input  logic               start_i,
   input  logic               annul_i,
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o
);

   localparam int CW = $clog2(WIDTH) + 1;

   localparam logic [1:0] DivFree   = 2'd0;
   localparam logic [1:0] DivByZero = 2'd1;
   localparam logic [1:0] DivOn     = 2'd2;
   localparam logic [1:0] DivEnd    = 2'd3;

   localparam logic [CW-1:0] CntDone = CW'(WIDTH);

   logic [1:0]         state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   dvd_q, dvd_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic [WIDTH-1:0]   dsr_q, dsr_d;
   logic               sgn_q, sgn_d;
   logic               s1_q, s1_d;
   logic               s2_q, s2_d;
   logic [2*WIDTH-1:0] result_q, result_d;
   logic               ready_q, ready_d;

   logic [WIDTH-1:0]   abs1;
   logic [WIDTH-1:0]   abs2;
   logic [WIDTH:0]     trial;
   logic [WIDTH:0]     diff;

   assign abs1 = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
   assign abs2 = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

   // Partial remainder stays below the divisor, so WIDTH+1 bits hold the trial.
   assign trial = {rem_q, dvd_q[WIDTH-1]};
   assign diff  = trial - {1'b0, dsr_q};

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      dvd_d    = dvd_q;
      rem_d    = rem_q;
      dsr_d    = dsr_q;
      sgn_d    = sgn_q;
      s1_d     = s1_q;
      s2_d     = s2_q;
      result_d = result_q;
      ready_d  = ready_q;

      unique case (state_q)
         DivFree: begin
            result_d = '0;
            ready_d  = 1'b0;
            if (start_i && !annul_i) begin
               sgn_d = signed_div_i;
               s1_d  = opdata1_i[WIDTH-1];
               s2_d  = opdata2_i[WIDTH-1];
               cnt_d = '0;
               rem_d = '0;
               dsr_d = abs2;
               if (opdata2_i == '0) begin
                  // Raw dividend is kept; it becomes the remainder.
                  dvd_d   = opdata1_i;
                  state_d = DivByZero;
               end else begin
                  dvd_d   = abs1;
                  state_d = DivOn;
               end
            end
         end

         DivByZero: begin
            rem_d   = dvd_q;
            dvd_d   = '1;
            state_d = DivEnd;
         end

         DivOn: begin
            if (annul_i) begin
               state_d  = DivFree;
               cnt_d    = '0;
               result_d = '0;
               ready_d  = 1'b0;
            end else if (cnt_q != CntDone) begin
               if (!diff[WIDTH]) begin
                  rem_d = diff[WIDTH-1:0];
                  dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
               end else begin
                  rem_d = trial[WIDTH-1:0];
                  dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
               end
               cnt_d = cnt_q + 1'b1;
            end else begin
               if (sgn_q && (s1_q ^ s2_q)) begin
                  dvd_d = -dvd_q;
               end
               if (sgn_q && s1_q) begin
                  rem_d = -rem_q;
               end
               cnt_d   = '0;
               state_d = DivEnd;
            end
         end

         DivEnd: begin
            if (start_i) begin
               result_d = {rem_q, dvd_q};
               ready_d  = 1'b1;
            end else begin
               result_d = '0;
               ready_d  = 1'b0;
               state_d  = DivFree;
            end
         end

         default: begin
            state_d  = DivFree;
            result_d = '0;
            ready_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= DivFree;
         cnt_q    <= '0;
         dvd_q    <= '0;
         rem_q    <= '0;
         dsr_q    <= '0;
         sgn_q    <= 1'b0;
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         result_q <= '0;
         ready_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         dvd_q    <= dvd_d;
         rem_q    <= rem_d;
         dsr_q    <= dsr_d;
         sgn_q    <= sgn_d;
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         result_q <= result_d;
         ready_q  <= ready_d;
      end
   end

   assign result_o = result_q;
   assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, results, annul and reset.
module tb_div_unit;

   logic        clk;
   logic        rst_n;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;

   int checks;
   int errors;

   div_unit #(.WIDTH(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Starts a division; returns edges from E0 until ready (41 = never).
   task automatic launch(input logic sg, input logic [31:0] a,
                         input logic [31:0] b, output int lat);
      @(posedge clk); #1;
      signed_div_i = sg;
      opdata1_i    = a;
      opdata2_i    = b;
      start_i      = 1'b1;
      @(posedge clk); #1;
      opdata1_i = 32'hDEAD_BEEF;
      opdata2_i = 32'h0000_0000;
      signed_div_i = ~sg;
      lat = 41;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); #1;
         if (ready_o) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic run_div(input string name, input logic sg,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int exp_lat);
      int lat;
      launch(sg, a, b, lat);
      checks++;
      if (lat !== exp_lat) begin
         errors++;
         $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
      end
      checks++;
      if (result_o !== exp) begin
         errors++;
         $display("FAIL %s result: got %h want %h", name, result_o, exp);
      end
      @(posedge clk); #1;
      checks++;
      if (ready_o !== 1'b1 || result_o !== exp) begin
         errors++;
         $display("FAIL %s hold: got %b/%h want 1/%h", name, ready_o,
                  result_o, exp);
      end
      start_i = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (ready_o !== 1'b0 || result_o !== 64'h0) begin
         errors++;
         $display("FAIL %s release: got %b/%h want 0/0", name, ready_o,
                  result_o);
      end
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      start_i = 1'b0;
      annul_i = 1'b0;
      signed_div_i = 1'b0;
      opdata1_i = '0;
      opdata2_i = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (ready_o !== 1'b0 || result_o !== 64'h0) begin
         errors++;
         $display("FAIL reset: got %b/%h want 0/0", ready_o, result_o);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_unsigned();
      run_div("divu_100_7", 1'b0, 32'd100, 32'd7,
              64'h00000002_0000000E, 34);
      run_div("divu_max_1", 1'b0, 32'hFFFFFFFF, 32'd1,
              64'h00000000_FFFFFFFF, 34);
      run_div("divu_big_2", 1'b0, 32'hFFFFFFF9, 32'd2,
              64'h00000001_7FFFFFFC, 34);
      run_div("divu_zero_dvd", 1'b0, 32'd0, 32'd5,
              64'h00000000_00000000, 34);
   endtask

   task automatic test_signed();
      run_div("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2,
              64'hFFFFFFFF_FFFFFFFD, 34);
      run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE,
              64'h00000001_FFFFFFFD, 34);
      run_div("div_m100_m7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9,
              64'hFFFFFFFE_0000000E, 34);
      run_div("div_overflow", 1'b1, 32'h80000000, 32'hFFFFFFFF,
              64'h00000000_80000000, 34);
   endtask

   task automatic test_div_by_zero();
      run_div("dbz_unsigned", 1'b0, 32'h12345678, 32'd0,
              64'h12345678_FFFFFFFF, 2);
      run_div("dbz_signed", 1'b1, 32'h80000000, 32'd0,
              64'h80000000_FFFFFFFF, 2);
   endtask

   task automatic test_annul();
      bit seen;
      @(posedge clk); #1;
      signed_div_i = 1'b0;
      opdata1_i = 32'd50;
      opdata2_i = 32'd7;
      start_i = 1'b1;
      @(posedge clk); #1;
      repeat (9) @(posedge clk);
      #1;
      annul_i = 1'b1;
      start_i = 1'b0;
      @(posedge clk); #1;
      annul_i = 1'b0;
      seen = 1'b0;
      for (int n = 0; n < 40; n++) begin
         if (ready_o) seen = 1'b1;
         @(posedge clk); #1;
      end
      checks++;
      if (seen !== 1'b0 || result_o !== 64'h0) begin
         errors++;
         $display("FAIL annul: ready seen %b result %h want 0/0", seen,
                  result_o);
      end
      run_div("after_annul_9_3", 1'b0, 32'd9, 32'd3,
              64'h00000000_00000003, 34);
   endtask

   task automatic test_async_reset();
      @(posedge clk); #1;
      signed_div_i = 1'b0;
      opdata1_i = 32'd1000;
      opdata2_i = 32'd3;
      start_i = 1'b1;
      @(posedge clk); #1;
      repeat (19) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if (ready_o !== 1'b0 || result_o !== 64'h0) begin
         errors++;
         $display("FAIL rst_mid_on: got %b/%h want 0/0", ready_o, result_o);
      end
      start_i = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      run_div("after_rst_50_5", 1'b0, 32'd50, 32'd5,
              64'h00000000_0000000A, 34);
   endtask

   task automatic test_reset_in_end();
      int lat;
      launch(1'b0, 32'd23, 32'd4, lat);
      checks++;
      if (ready_o !== 1'b1 || result_o !== 64'h00000003_00000005) begin
         errors++;
         $display("FAIL end_pre_rst: got %b/%h want 1/0000000300000005",
                  ready_o, result_o);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (ready_o !== 1'b0 || result_o !== 64'h0) begin
         errors++;
         $display("FAIL rst_in_end: got %b/%h want 0/0", ready_o, result_o);
      end
      start_i = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_unsigned();
      test_signed();
      test_div_by_zero();
      test_annul();
      test_async_reset();
      test_reset_in_end();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
